// File: rtl/restoring_divider_pkg.sv
// rtl/restoring_divider_pkg.sv - shared state encoding for the restoring divider
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic state_is_busy(input div_state_e s);
    return (s == ST_CALC) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/restoring_divider_ctrl.sv
// rtl/restoring_divider_ctrl.sv - controller FSM and iteration counter for the divider
module restoring_divider_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic i_start,
  input  logic i_divisor_zero,
  output logic o_ld_a,
  output logic o_ld_q,
  output logic o_ld_m,
  output logic o_sft,
  output logic o_ldres,
  output logic o_setdbz,
  output logic o_busy,
  output logic o_done
);
  import restoring_divider_pkg::*;

  div_state_e    r_state;
  logic [CW-1:0] r_count;
  logic          r_dbz_run;
  logic          r_busy;
  logic          r_done;
  logic          w_accept;
  logic          w_last;

  always_comb begin
    w_accept = (r_state == ST_IDLE) && i_start;
    w_last   = (r_count == CW'(1));
    o_ld_a   = w_accept && !i_divisor_zero;
    o_ld_q   = w_accept && !i_divisor_zero;
    o_ld_m   = w_accept && !i_divisor_zero;
    o_setdbz = w_accept && i_divisor_zero;
    // a divide-by-zero run spends one idle CALC cycle so done lands one edge later
    o_sft    = (r_state == ST_CALC) && !r_dbz_run;
    o_ldres  = o_sft && w_last;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_dbz_run <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state   <= ST_CALC;
            r_count   <= i_divisor_zero ? CW'(1) : CW'(N);
            r_dbz_run <= i_divisor_zero;
            r_busy    <= state_is_busy(ST_CALC);
          end
        end
        ST_CALC: begin
          r_count <= r_count - CW'(1);
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= state_is_busy(ST_DONE);
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_done    <= 1'b0;
          r_dbz_run <= 1'b0;
          r_busy    <= state_is_busy(ST_IDLE);
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module restoring_divider #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         dbz,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);
  import restoring_divider_pkg::*;

  logic [N:0]   r_a;
  logic [N-1:0] r_q;
  logic [N-1:0] r_m;
  logic [N-1:0] r_quot;
  logic [N-1:0] r_rem;
  logic         r_dbz;

  logic         w_ld_a;
  logic         w_ld_q;
  logic         w_ld_m;
  logic         w_sft;
  logic         w_ldres;
  logic         w_setdbz;
  logic         w_divisor_zero;
  logic [N:0]   w_s;
  logic [N:0]   w_t;
  logic         w_neg;
  logic [N:0]   w_a_nxt;
  logic [N-1:0] w_q_nxt;
  logic         w_unused_a_msb;

  assign w_divisor_zero = (divisor == '0);

  restoring_divider_ctrl #(
    .N  (N),
    .CW (CW)
  ) u_ctrl (
    .clk            (clk),
    .clr_n          (clr_n),
    .i_start        (start),
    .i_divisor_zero (w_divisor_zero),
    .o_ld_a         (w_ld_a),
    .o_ld_q         (w_ld_q),
    .o_ld_m         (w_ld_m),
    .o_sft          (w_sft),
    .o_ldres        (w_ldres),
    .o_setdbz       (w_setdbz),
    .o_busy         (busy),
    .o_done         (done)
  );

  // A stays below M after every step, so its MSB only matters inside the subtract
  always_comb begin
    w_s            = {r_a[N-1:0], r_q[N-1]};
    w_t            = w_s - {1'b0, r_m};
    w_neg          = w_t[N];
    w_a_nxt        = w_neg ? w_s : w_t;
    w_q_nxt        = {r_q[N-2:0], ~w_neg};
    w_unused_a_msb = r_a[N];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_a    <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_ld_a)     r_a <= '0;
      else if (w_sft) r_a <= w_a_nxt;

      if (w_ld_q)     r_q <= dividend;
      else if (w_sft) r_q <= w_q_nxt;

      if (w_ld_m) r_m <= divisor;

      if (w_ld_m)        r_dbz <= 1'b0;
      else if (w_setdbz) r_dbz <= 1'b1;

      if (w_setdbz) begin
        r_quot <= '1;
        r_rem  <= dividend;
      end else if (w_ldres) begin
        r_quot <= w_q_nxt;
        r_rem  <= w_a_nxt[N-1:0];
      end
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - directed and random checks of restoring_divider against arithmetic reference
module tb_restoring_divider;
  localparam int N  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  restoring_divider #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one division from IDLE; returns one cycle after done so the DUT is back in IDLE.
  task automatic run_op(input logic [N-1:0] n, input logic [N-1:0] d,
                        input bit full, input int inj_cyc);
    logic [N-1:0] eq, er;
    int exp_lat, cyc, nbusy;
    eq      = (d == 0) ? {N{1'b1}} : N'(n / d);
    er      = (d == 0) ? n : N'(n % d);
    exp_lat = (d == 0) ? 2 : N + 1;
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    nbusy = 0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      if (cyc == inj_cyc) begin
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
      end else if (inj_cyc > 0) begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    if (busy) nbusy++;
    start = 1'b0;
    chk("latency", cyc, exp_lat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("dbz", dbz, (d == 0));
    if (full) chk("busy_cycles", nbusy, exp_lat);
    step();
    if (full) begin
      chk("done_pulse_len", done, 0);
      chk("quotient_held", quotient, eq);
      chk("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, extra;
    logic [N-1:0] rn, rd;

    clr_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", dbz, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    step();
    clr_n = 1'b1;
    step();

    run_op(8'd100, 8'd7, 1'b1, 0);
    run_op(8'd255, 8'd1, 1'b1, 0);
    run_op(8'd3, 8'd10, 1'b1, 0);
    run_op(8'd0, 8'd5, 1'b1, 0);
    run_op(8'd5, 8'd0, 1'b1, 0);
    run_op(8'd100, 8'd7, 1'b1, 0);

    run_op(8'd100, 8'd7, 1'b1, 4);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) extra++;
      step();
    end
    chk("ignored_start_no_done", extra, 0);

    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    clr_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dbz", dbz, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) extra++;
      if (i == 3) clr_n = 1'b1;
      step();
    end
    chk("abort_no_done", extra, 0);
    run_op(8'd200, 8'd3, 1'b1, 0);

    dividend = 8'd50;
    divisor  = 8'd6;
    start    = 1'b1;
    step();
    dividend = 8'd9;
    divisor  = 8'd9;
    cyc = 1;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    chk("b2b_first_latency", cyc, N + 1);
    chk("b2b_first_quotient", quotient, 8);
    chk("b2b_first_remainder", remainder, 2);
    step();
    chk("b2b_gap_idle", busy, 0);
    step();
    chk("b2b_second_accepted", busy, 1);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    chk("b2b_second_latency", cyc, N + 1);
    chk("b2b_second_quotient", quotient, 1);
    chk("b2b_second_remainder", remainder, 0);
    step();

    for (int k = 0; k < 2000; k++) begin
      rn = N'($urandom);
      if ($urandom_range(0, 3) == 0) rd = N'($urandom_range(0, 15));
      else rd = N'($urandom);
      run_op(rn, rd, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
